control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, with ports named as below.
REQ-002 SHALL provide the following ports:
- CLK  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- opcode  in  7  IR[6:0] from datapath.
- funct3  in  3  IR[14:12].
- funct7_5  in  1  IR[30].
- branch_taken  in  1  datapath comparison result for current branch.
- load_ir  out  1  IR load enable.
- load_pc  out  1  PC load enable.
- WE_RF  out  1  register-file write enable.
- WE_MEM  out  1  data-memory write enable.
- ULA_din2_sel  out  1  ALU operand 2 select: 0=rs2, 1=immediate.
- RF_din_sel  out  2  RF write source: 0=memory, 1=ALU, 2=PC+4, 3=PC adder.
- pc_adder_sel  out  1  PC adder base: 0=rs1, 1=PC.
- pc_next_sel  out  1  next PC: 0=PC+4, 1=PC adder.
- ula_op  out  2  ALU operation: 0=add, 1=sub/compare, 2=decode funct3/funct7_5.
- illegal  out  1  sticky illegal-opcode flag.
- instret  out  32  retired-instruction count.

Function
REQ-003 SHALL implement a multicycle Moore FSM with states FETCH, DECODE, EXEC, MEM, WB and TRAP; outputs depend on state and opcode only.
REQ-004 SHALL drive every output to 0 in any state/opcode combination not listed in REQ-005..REQ-010.
REQ-005 In FETCH: load_ir=1; next state DECODE.
REQ-006 In DECODE: all enables 0. Next state is EXEC for opcodes 0000011, 0100011, 0110011, 0010011, 0010111, 1100011, 1101111 and 1100111; any other opcode goes to TRAP.
REQ-007 In EXEC:
- ULA_din2_sel=0 for R-type (0110011) and branch (1100011), 1 otherwise.
- ula_op=2 for R-type and I-arith, 1 for branch, 0 otherwise.
- Load/store: next state MEM.
- Branch: load_pc=1, pc_adder_sel=1, pc_next_sel=branch_taken; next state FETCH.
- All other legal opcodes: next state WB.
REQ-008 In MEM:
- Store: WE_MEM=1, load_pc=1, pc_next_sel=0; next state FETCH.
- Load: no enables; next state WB.
REQ-009 In WB: WE_RF=1 and load_pc=1, with the remaining outputs set per opcode:
- Load: RF_din_sel=0, pc_next_sel=0.
- R-type / I-arith: RF_din_sel=1, pc_next_sel=0.
- auipc: RF_din_sel=3, pc_adder_sel=1, pc_next_sel=0.
- jal: RF_din_sel=2, pc_adder_sel=1, pc_next_sel=1.
- jalr: RF_din_sel=2, pc_adder_sel=0, pc_next_sel=1.
- Next state FETCH.
REQ-010 In TRAP: illegal=1 and all enables 0; the FSM remains in TRAP until reset.
REQ-011 ULA_din2_sel and ula_op SHALL hold their EXEC values through MEM and WB of the same instruction, because the datapath has no ALU-output register.
REQ-012 instret SHALL increment by 1 on every clock edge at which load_pc=1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-013 Latency SHALL be 3 cycles for branch, 4 for store and ALU/auipc/jal/jalr, and 5 for load, measured FETCH to FETCH.
REQ-014 opcode is sampled only in DECODE, EXEC, MEM and WB; in FETCH it is ignored.

Reset
REQ-015 reset sampled high SHALL set state=FETCH, instret=0 and illegal=0 at the next edge, and SHALL override any in-flight transition, including TRAP.
REQ-016 While reset is high, all outputs SHALL be 0, including load_ir, so that no write is issued during the reset cycle.
REQ-017 Asserting reset mid-instruction SHALL abort that instruction without a PC or RF update at that edge.

Structure
REQ-018 A shared package riscv_ctrl_pkg SHALL hold the opcode constants, the state encoding, and the RF_din_sel and ula_op encodings; datapath and benches SHALL import it.
REQ-019 The opcode classifier (opcode to is_load/is_store/is_rtype/is_iarith/is_auipc/is_branch/is_jal/is_jalr/legal) SHALL be one combinational sub-module, control_decoder.
REQ-020 control_unit SHALL instantiate datapath-independent logic only; integration is done by a top-level wrapper.

Verification
REQ-021 Reset, then opcode=0000011 -> load_ir=1 at cycle 0; WE_RF=1 and RF_din_sel=0 at cycle 4; instret=1 after that edge.
REQ-022 opcode=0100011 -> WE_MEM=1 and load_pc=1 at cycle 3; WE_RF remains 0 throughout.
REQ-023 Branch with branch_taken=1, then 0 -> EXEC shows pc_next_sel=1, then pc_next_sel=0, with load_pc=1 both times; each branch takes 3 cycles.
REQ-024 Sequence auipc, jal, jalr -> WB outputs (RF_din_sel, pc_adder_sel, pc_next_sel) are (3,1,0), (2,1,1) and (2,0,1) respectively.
REQ-025 opcode=0110111 -> TRAP entered after DECODE; illegal=1 and instret frozen until reset, after which illegal=0 and state=FETCH.
REQ-026 Preload instret=0xFFFFFFFF via forced retirement, then one more retire -> instret=0; reset asserted in MEM of a store -> WE_MEM=0 at that edge.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared opcode, state and select encodings for the multicycle control unit
//
// Contents:
//   OP_*        RV32I major opcodes recognised by the control path
//   ST_*        FSM state encoding (legacy 3-bit constants)
//   RF_SEL_*    register-file write-source select encoding
//   ULA_*       ALU operation class encoding
//   op_class_t  classifier result produced by control_decoder
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    localparam logic [1:0] RF_SEL_MEM   = 2'd0;
    localparam logic [1:0] RF_SEL_ALU   = 2'd1;
    localparam logic [1:0] RF_SEL_PC4   = 2'd2;
    localparam logic [1:0] RF_SEL_PCADD = 2'd3;

    localparam logic [1:0] ULA_ADD   = 2'd0;
    localparam logic [1:0] ULA_SUB   = 2'd1;
    localparam logic [1:0] ULA_FUNCT = 2'd2;

    typedef struct packed {
        logic is_load;
        logic is_store;
        logic is_rtype;
        logic is_iarith;
        logic is_auipc;
        logic is_branch;
        logic is_jal;
        logic is_jalr;
        logic legal;
    } op_class_t;

endpackage

// File: rtl/control_decoder.sv
// rtl/control_decoder.sv - combinational opcode classifier
//
// Ports:
//   opcode  in   7  IR[6:0]
//   cls     out     one-hot class flags plus legal (any recognised opcode)
module control_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_LOAD:   cls.is_load   = 1'b1;
            OP_STORE:  cls.is_store  = 1'b1;
            OP_RTYPE:  cls.is_rtype  = 1'b1;
            OP_IARITH: cls.is_iarith = 1'b1;
            OP_AUIPC:  cls.is_auipc  = 1'b1;
            OP_BRANCH: cls.is_branch = 1'b1;
            OP_JAL:    cls.is_jal    = 1'b1;
            OP_JALR:   cls.is_jalr   = 1'b1;
            default:   cls = '0;
        endcase
        cls.legal = cls.is_load | cls.is_store | cls.is_rtype | cls.is_iarith |
                    cls.is_auipc | cls.is_branch | cls.is_jal | cls.is_jalr;
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle Moore control FSM for an RV32I subset datapath
//
// Ports:
//   CLK, reset          clock and synchronous active-high reset
//   opcode/funct3/funct7_5/branch_taken   instruction fields and branch compare from datapath
//   load_ir, load_pc, WE_RF, WE_MEM       datapath enables
//   ULA_din2_sel, RF_din_sel, pc_adder_sel, pc_next_sel, ula_op   datapath mux/ALU selects
//   illegal             sticky illegal-opcode flag
//   instret             retired-instruction counter (counts load_pc edges)
module control_unit
    import riscv_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic        branch_taken,
    output logic        load_ir,
    output logic        load_pc,
    output logic        WE_RF,
    output logic        WE_MEM,
    output logic        ULA_din2_sel,
    output logic [1:0]  RF_din_sel,
    output logic        pc_adder_sel,
    output logic        pc_next_sel,
    output logic [1:0]  ula_op,
    output logic        illegal,
    output logic [31:0] instret
);

    // funct fields are decoded by the ALU control downstream when ula_op selects it
    logic unused_funct;
    assign unused_funct = ^{funct3, funct7_5};

    op_class_t   cls;
    logic [2:0]  state_q, state_d;
    logic        illegal_q;
    logic [31:0] instret_q;

    logic        load_ir_c, load_pc_c, we_rf_c, we_mem_c, din2_c, pc_adder_c, pc_next_c;
    logic [1:0]  rf_sel_c, ula_op_c;

    control_decoder u_decoder (
        .opcode (opcode),
        .cls    (cls)
    );

    always_comb begin
        state_d    = state_q;
        load_ir_c  = 1'b0;
        load_pc_c  = 1'b0;
        we_rf_c    = 1'b0;
        we_mem_c   = 1'b0;
        din2_c     = 1'b0;
        rf_sel_c   = RF_SEL_MEM;
        pc_adder_c = 1'b0;
        pc_next_c  = 1'b0;
        ula_op_c   = ULA_ADD;

        // No ALU output register: operand select and operation stay up
        // from EXEC until the result is consumed in MEM or WB.
        if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
            din2_c = ~(cls.is_rtype | cls.is_branch);
            if (cls.is_rtype || cls.is_iarith)
                ula_op_c = ULA_FUNCT;
            else if (cls.is_branch)
                ula_op_c = ULA_SUB;
        end

        case (state_q)
            ST_FETCH: begin
                load_ir_c = 1'b1;
                state_d   = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = cls.legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                if (cls.is_load || cls.is_store) begin
                    state_d = ST_MEM;
                end else if (cls.is_branch) begin
                    load_pc_c  = 1'b1;
                    pc_adder_c = 1'b1;
                    pc_next_c  = branch_taken;
                    state_d    = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (cls.is_store) begin
                    we_mem_c  = 1'b1;
                    load_pc_c = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                we_rf_c   = 1'b1;
                load_pc_c = 1'b1;
                state_d   = ST_FETCH;
                if (cls.is_auipc) begin
                    rf_sel_c   = RF_SEL_PCADD;
                    pc_adder_c = 1'b1;
                end else if (cls.is_jal) begin
                    rf_sel_c   = RF_SEL_PC4;
                    pc_adder_c = 1'b1;
                    pc_next_c  = 1'b1;
                end else if (cls.is_jalr) begin
                    rf_sel_c   = RF_SEL_PC4;
                    pc_next_c  = 1'b1;
                end else if (cls.is_rtype || cls.is_iarith) begin
                    rf_sel_c   = RF_SEL_ALU;
                end
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            instret_q <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_pc_c)
                instret_q <= instret_q + 32'd1;
            if (state_d == ST_TRAP)
                illegal_q <= 1'b1;
        end
    end

    // Reset blanks every output so nothing is written during the reset cycle.
    assign load_ir      = ~reset & load_ir_c;
    assign load_pc      = ~reset & load_pc_c;
    assign WE_RF        = ~reset & we_rf_c;
    assign WE_MEM       = ~reset & we_mem_c;
    assign ULA_din2_sel = ~reset & din2_c;
    assign RF_din_sel   = reset ? 2'b00 : rf_sel_c;
    assign pc_adder_sel = ~reset & pc_adder_c;
    assign pc_next_sel  = ~reset & pc_next_c;
    assign ula_op       = reset ? 2'b00 : ula_op_c;
    assign illegal      = ~reset & illegal_q;
    assign instret      = reset ? 32'd0 : instret_q;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - table-driven scoreboard bench for control_unit
module tb_control_unit;
    import riscv_ctrl_pkg::*;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'h7F;
    logic [2:0]  funct3 = 3'd0;
    logic        funct7_5 = 1'b0;
    logic        branch_taken = 1'b0;
    logic        load_ir, load_pc, WE_RF, WE_MEM, ULA_din2_sel, pc_adder_sel, pc_next_sel, illegal;
    logic [1:0]  RF_din_sel, ula_op;
    logic [31:0] instret;

    control_unit dut (
        .CLK          (CLK),
        .reset        (reset),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7_5     (funct7_5),
        .branch_taken (branch_taken),
        .load_ir      (load_ir),
        .load_pc      (load_pc),
        .WE_RF        (WE_RF),
        .WE_MEM       (WE_MEM),
        .ULA_din2_sel (ULA_din2_sel),
        .RF_din_sel   (RF_din_sel),
        .pc_adder_sel (pc_adder_sel),
        .pc_next_sel  (pc_next_sel),
        .ula_op       (ula_op),
        .illegal      (illegal),
        .instret      (instret)
    );

    always #5 CLK = ~CLK;

    // vector bits: [11]load_ir [10]load_pc [9]WE_RF [8]WE_MEM [7]ULA_din2_sel
    //              [6:5]RF_din_sel [4]pc_adder_sel [3]pc_next_sel [2:1]ula_op [0]illegal
    typedef struct {
        logic [6:0]       op;
        logic             tk;
        int               n;
        logic [0:4][11:0] v;
        string            name;
    } instr_t;

    typedef struct {
        logic [11:0] vec;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    exp_t        sb[$];
    instr_t      tbl[9];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_instret = 32'd0;

    function automatic logic [11:0] outs();
        return {load_ir, load_pc, WE_RF, WE_MEM, ULA_din2_sel, RF_din_sel,
                pc_adder_sel, pc_next_sel, ula_op, illegal};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, queue the expectation, compare after settling, advance.
    task automatic step(input logic rst, input logic [6:0] op, input logic tk,
                        input logic [11:0] exp_vec, input string name);
        exp_t e;
        reset = rst;
        opcode = op;
        branch_taken = tk;
        sb.push_back('{vec: (rst ? 12'h000 : exp_vec), cnt: (rst ? 32'd0 : model_instret), name: name});
        #1;
        e = sb.pop_front();
        check({e.name, " outs"}, {20'd0, outs()}, {20'd0, e.vec});
        check({e.name, " instret"}, instret, e.cnt);
        @(posedge CLK);
        if (rst)
            model_instret = 32'd0;
        else if (e.vec[10])
            model_instret = model_instret + 32'd1;
        @(negedge CLK);
    endtask

    // Opcode is garbage during FETCH: it must be ignored there.
    task automatic run_instr(input instr_t t);
        for (int c = 0; c < t.n; c++)
            step(1'b0, (c == 0) ? 7'h7F : t.op, t.tk, t.v[c], $sformatf("%s c%0d", t.name, c));
    endtask

    initial begin
        tbl[0] = '{OP_LOAD,   1'b0, 5, {12'h800, 12'h000, 12'h080, 12'h080, 12'h680}, "load"};
        tbl[1] = '{OP_STORE,  1'b0, 4, {12'h800, 12'h000, 12'h080, 12'h580, 12'h000}, "store"};
        tbl[2] = '{OP_BRANCH, 1'b1, 3, {12'h800, 12'h000, 12'h41A, 12'h000, 12'h000}, "br_taken"};
        tbl[3] = '{OP_BRANCH, 1'b0, 3, {12'h800, 12'h000, 12'h412, 12'h000, 12'h000}, "br_not"};
        tbl[4] = '{OP_RTYPE,  1'b0, 4, {12'h800, 12'h000, 12'h004, 12'h624, 12'h000}, "rtype"};
        tbl[5] = '{OP_IARITH, 1'b1, 4, {12'h800, 12'h000, 12'h084, 12'h6A4, 12'h000}, "iarith"};
        tbl[6] = '{OP_AUIPC,  1'b0, 4, {12'h800, 12'h000, 12'h080, 12'h6F0, 12'h000}, "auipc"};
        tbl[7] = '{OP_JAL,    1'b0, 4, {12'h800, 12'h000, 12'h080, 12'h6D8, 12'h000}, "jal"};
        tbl[8] = '{OP_JALR,   1'b1, 4, {12'h800, 12'h000, 12'h080, 12'h6C8, 12'h000}, "jalr"};

        step(1'b1, OP_LOAD, 1'b0, 12'h000, "reset0");
        step(1'b1, OP_LOAD, 1'b0, 12'h000, "reset1");

        for (int i = 0; i < 9; i++)
            run_instr(tbl[i]);

        // Illegal opcode: trap after DECODE, stuck with instret frozen until reset.
        step(1'b0, 7'h7F,      1'b0, 12'h800, "ill fetch");
        step(1'b0, 7'b0110111, 1'b0, 12'h000, "ill decode");
        for (int i = 0; i < 4; i++)
            step(1'b0, (i[0] ? OP_LOAD : OP_BRANCH), 1'b1, 12'h001, $sformatf("trap%0d", i));
        step(1'b1, OP_LOAD, 1'b0, 12'h000, "trap reset");
        run_instr(tbl[4]);

        // Counter wrap: preload all-ones, then retire one branch.
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        model_instret = 32'hFFFF_FFFF;
        run_instr(tbl[2]);
        run_instr(tbl[7]);

        // Reset during MEM of a store: the write must not be issued.
        step(1'b0, 7'h7F,    1'b0, 12'h800, "abort fetch");
        step(1'b0, OP_STORE, 1'b0, 12'h000, "abort decode");
        step(1'b0, OP_STORE, 1'b0, 12'h080, "abort exec");
        step(1'b1, OP_STORE, 1'b0, 12'h000, "abort mem");
        run_instr(tbl[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
